// File: rtl/demux4_tdm_capture_if.sv
// ============================================================================
// Module  : demux4_tdm_capture_if
// Brief   : TDM beat stream (data, qualifier, start-of-frame) into the demux.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface demux4_tdm_capture_if #(
    parameter int W = 1
);
    logic [W-1:0] din;
    logic         din_valid;
    logic         sof;

    modport master (
        output din,
        output din_valid,
        output sof
    );

    modport slave (
        input din,
        input din_valid,
        input sof
    );
endinterface

`default_nettype wire

// File: rtl/demux4_tdm_capture.sv
// ============================================================================
// Module  : demux4_tdm_capture
// Brief   : Rebuilds four parallel channels from a d0,d1,d2,d3 TDM stream.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module demux4_tdm_capture #(
    parameter int W = 1
) (
    input  wire logic               clk,
    input  wire logic               rst,
    demux4_tdm_capture_if.slave     tdm,
    output logic [W-1:0]            y0,
    output logic [W-1:0]            y1,
    output logic [W-1:0]            y2,
    output logic [W-1:0]            y3,
    output logic [1:0]              sel,
    output logic                    busy,
    output logic                    frame_valid,
    output logic                    frame_err
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t       r_state, w_state_nxt;
    logic [1:0]   r_cnt, w_cnt_nxt;
    logic [W-1:0] r_sh0, r_sh1, r_sh2;
    logic [W-1:0] w_sh0_nxt, w_sh1_nxt, w_sh2_nxt;
    logic [W-1:0] r_y0, r_y1, r_y2, r_y3;
    logic [W-1:0] w_y0_nxt, w_y1_nxt, w_y2_nxt, w_y3_nxt;
    logic         r_fv, w_fv_nxt;
    logic         r_fe, w_fe_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
            r_sh0   <= '0;
            r_sh1   <= '0;
            r_sh2   <= '0;
            r_y0    <= '0;
            r_y1    <= '0;
            r_y2    <= '0;
            r_y3    <= '0;
            r_fv    <= 1'b0;
            r_fe    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sh0   <= w_sh0_nxt;
            r_sh1   <= w_sh1_nxt;
            r_sh2   <= w_sh2_nxt;
            r_y0    <= w_y0_nxt;
            r_y1    <= w_y1_nxt;
            r_y2    <= w_y2_nxt;
            r_y3    <= w_y3_nxt;
            r_fv    <= w_fv_nxt;
            r_fe    <= w_fe_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sh0_nxt   = r_sh0;
        w_sh1_nxt   = r_sh1;
        w_sh2_nxt   = r_sh2;
        w_y0_nxt    = r_y0;
        w_y1_nxt    = r_y1;
        w_y2_nxt    = r_y2;
        w_y3_nxt    = r_y3;
        w_fv_nxt    = 1'b0;
        w_fe_nxt    = 1'b0;

        if (tdm.din_valid) begin
            case (r_state)
                IDLE: begin
                    if (tdm.sof) begin
                        w_sh0_nxt   = tdm.din;
                        w_cnt_nxt   = 2'd1;
                        w_state_nxt = COLLECT;
                    end
                end
                COLLECT: begin
                    if (tdm.sof) begin
                        // Early restart: drop the partial frame, this beat is channel 0.
                        w_fe_nxt  = 1'b1;
                        w_sh0_nxt = tdm.din;
                        w_cnt_nxt = 2'd1;
                    end else begin
                        case (r_cnt)
                            2'd0: begin
                                w_sh0_nxt = tdm.din;
                                w_cnt_nxt = 2'd1;
                            end
                            2'd1: begin
                                w_sh1_nxt = tdm.din;
                                w_cnt_nxt = 2'd2;
                            end
                            2'd2: begin
                                w_sh2_nxt = tdm.din;
                                w_cnt_nxt = 2'd3;
                            end
                            default: begin
                                // Last beat bypasses the shadows so the frame lands atomically.
                                w_y0_nxt    = r_sh0;
                                w_y1_nxt    = r_sh1;
                                w_y2_nxt    = r_sh2;
                                w_y3_nxt    = tdm.din;
                                w_fv_nxt    = 1'b1;
                                w_cnt_nxt   = 2'd0;
                                w_state_nxt = IDLE;
                            end
                        endcase
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 2'd0;
                end
            endcase
        end
    end

    assign y0          = r_y0;
    assign y1          = r_y1;
    assign y2          = r_y2;
    assign y3          = r_y3;
    assign sel         = r_cnt;
    assign busy        = (r_state == COLLECT);
    assign frame_valid = r_fv;
    assign frame_err   = r_fe;

endmodule

`default_nettype wire

// File: tb/tb_demux4_tdm_capture.sv
// ============================================================================
// Module  : tb_demux4_tdm_capture
// Brief   : Directed self-checking bench for demux4_tdm_capture (W=1).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux4_tdm_capture;

    localparam int W = 1;

    logic         clk;
    logic         rst;
    logic [W-1:0] y0, y1, y2, y3;
    logic [1:0]   sel;
    logic         busy;
    logic         frame_valid;
    logic         frame_err;

    int n_assert = 0;
    int n_fail   = 0;

    demux4_tdm_capture_if #(.W(W)) tdm ();

    demux4_tdm_capture #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .tdm         (tdm.slave),
        .y0          (y0),
        .y1          (y1),
        .y2          (y2),
        .y3          (y3),
        .sel         (sel),
        .busy        (busy),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full observable state: {y3,y2,y1,y0}, sel, busy, frame_valid, frame_err.
    task automatic chk_all(input string tag, input logic [3:0] y, input logic [1:0] s,
                           input logic b, input logic fv, input logic fe);
        chk({tag, ".y"},  {4'b0, y3, y2, y1, y0}, {4'b0, y});
        chk({tag, ".sel"}, {6'b0, sel}, {6'b0, s});
        chk({tag, ".busy"}, {7'b0, busy}, {7'b0, b});
        chk({tag, ".fv"}, {7'b0, frame_valid}, {7'b0, fv});
        chk({tag, ".fe"}, {7'b0, frame_err}, {7'b0, fe});
    endtask

    // Present one cycle of stimulus, then sample 1 time unit after the edge.
    task automatic cycle(input logic v, input logic s, input logic d);
        tdm.din_valid = v;
        tdm.sof       = s;
        tdm.din       = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        tdm.din_valid = 1'b0;
        tdm.sof       = 1'b0;
        tdm.din       = '0;

        // Reset held two cycles, released away from the edge
        repeat (2) @(posedge clk);
        #1;
        chk_all("rst_held", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk_all("rst_rel", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

        // Frame 1001: d0=1,d1=0,d2=0,d3=1
        cycle(1, 1, 1); chk_all("f1_b0", 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0);
        cycle(1, 0, 0); chk_all("f1_b1", 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0);
        cycle(1, 0, 0); chk_all("f1_b2", 4'b0000, 2'd3, 1'b1, 1'b0, 1'b0);
        cycle(1, 0, 1); chk_all("f1_b3", 4'b1001, 2'd0, 1'b0, 1'b1, 1'b0);

        // Frame 0110 back-to-back, two idle cycles between beats 2 and 3
        cycle(1, 1, 0); chk_all("f2_b0", 4'b1001, 2'd1, 1'b1, 1'b0, 1'b0);
        cycle(1, 0, 1); chk_all("f2_b1", 4'b1001, 2'd2, 1'b1, 1'b0, 1'b0);
        cycle(0, 0, 1); chk_all("f2_gap0", 4'b1001, 2'd2, 1'b1, 1'b0, 1'b0);
        cycle(0, 1, 0); chk_all("f2_gap1", 4'b1001, 2'd2, 1'b1, 1'b0, 1'b0);
        cycle(1, 0, 1); chk_all("f2_b2", 4'b1001, 2'd3, 1'b1, 1'b0, 1'b0);
        cycle(1, 0, 0); chk_all("f2_b3", 4'b0110, 2'd0, 1'b0, 1'b1, 1'b0);

        // Early sof: 1(sof),1 then 0(sof),1,1,0
        cycle(1, 1, 1); chk_all("es_b0", 4'b0110, 2'd1, 1'b1, 1'b0, 1'b0);
        cycle(1, 0, 1); chk_all("es_b1", 4'b0110, 2'd2, 1'b1, 1'b0, 1'b0);
        cycle(1, 1, 0); chk_all("es_restart", 4'b0110, 2'd1, 1'b1, 1'b0, 1'b1);
        cycle(1, 0, 1); chk_all("es_b1n", 4'b0110, 2'd2, 1'b1, 1'b0, 1'b0);
        cycle(1, 0, 1); chk_all("es_b2n", 4'b0110, 2'd3, 1'b1, 1'b0, 1'b0);
        cycle(1, 0, 0); chk_all("es_b3n", 4'b0110, 2'd0, 1'b0, 1'b1, 1'b0);
        cycle(0, 0, 0); chk_all("es_after", 4'b0110, 2'd0, 1'b0, 1'b0, 1'b0);

        // Non-sof beats while IDLE are discarded
        cycle(1, 0, 1); chk_all("idle_b0", 4'b0110, 2'd0, 1'b0, 1'b0, 1'b0);
        cycle(1, 0, 1); chk_all("idle_b1", 4'b0110, 2'd0, 1'b0, 1'b0, 1'b0);
        cycle(1, 0, 1); chk_all("idle_b2", 4'b0110, 2'd0, 1'b0, 1'b0, 1'b0);
        cycle(0, 1, 1); chk_all("idle_nv", 4'b0110, 2'd0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset after two beats of a frame
        cycle(1, 1, 1); chk_all("ar_b0", 4'b0110, 2'd1, 1'b1, 1'b0, 1'b0);
        cycle(1, 0, 0); chk_all("ar_b1", 4'b0110, 2'd2, 1'b1, 1'b0, 1'b0);
        tdm.din_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_all("ar_async", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk_all("ar_rel", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

        // Full frame 1001 after the reset
        cycle(1, 1, 1); chk_all("f3_b0", 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0);
        cycle(1, 0, 0); chk_all("f3_b1", 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0);
        cycle(1, 0, 0); chk_all("f3_b2", 4'b0000, 2'd3, 1'b1, 1'b0, 1'b0);
        cycle(1, 0, 1); chk_all("f3_b3", 4'b1001, 2'd0, 1'b0, 1'b1, 1'b0);
        cycle(0, 0, 0); chk_all("f3_after", 4'b1001, 2'd0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/demux4_tdm_capture.md
Name: demux4_tdm_capture

Overview:
- Receive-side counterpart of the team's 4:1 multiplexer: rebuilds four parallel channels from a time-division stream of the form d0,d1,d2,d3 per frame.
- A frame-start marker and a channel counter steer each beat into a shadow register.
- A completed frame is transferred atomically to the registered outputs y0..y3, with a one-cycle frame_valid pulse.
- Sits between a serial/TDM link and parallel consumers.

Parameters:
- W, 1, data width of each channel and of din.

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  reset, asynchronous, active-high
- din  input  W  TDM data beat
- din_valid  input  1  beat qualifier; a beat is din_valid=1 at a rising clk edge
- sof  input  1  start-of-frame, meaningful only with din_valid=1; marks the channel-0 beat
- y0  output  W  channel 0 of the last complete frame
- y1  output  W  channel 1 of the last complete frame
- y2  output  W  channel 2 of the last complete frame
- y3  output  W  channel 3 of the last complete frame
- sel  output  2  index of the next expected channel (0..3)
- busy  output  1  high while a frame is partially collected
- frame_valid  output  1  one-cycle pulse: y0..y3 were just updated
- frame_err  output  1  one-cycle pulse: partial frame discarded because sof arrived early

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-high.
- Reset: while rst=1, independent of clk:
  - all outputs are 0: y0..y3, sel, busy, frame_valid, frame_err
  - shadow registers are 0, cnt=0, state=IDLE
  - reset mid-frame discards the partial frame with no frame_err.
- FSM has two states, IDLE and COLLECT. cnt is 2 bits. All outputs are registered.
- IDLE:
  - beat with sof=1: shadow0<=din, cnt<=1, go to COLLECT
  - beat with sof=0: discarded; no state change, no error
  - no beat: hold.
- COLLECT, beat with sof=0 and cnt<3: shadow[cnt]<=din, cnt<=cnt+1.
- COLLECT, beat with sof=0 and cnt=3 (frame completes):
  - at that same edge, y0..y2<=shadow0..2 and y3<=din
  - frame_valid<=1 for exactly one cycle
  - cnt<=0, go to IDLE.
- COLLECT, beat with sof=1 (early restart):
  - frame_err<=1 for one cycle
  - y0..y3 are unchanged
  - shadow0<=din, cnt<=1, stay in COLLECT.
- COLLECT, no beat: hold everything. Idle gaps inside a frame are legal and unbounded.
- sel = cnt. busy = (state==COLLECT).
- frame_valid and frame_err default to 0 every cycle unless set as above. They are never both 1 in the same cycle.
- Latency: y0..y3 and frame_valid change at the edge that samples the 4th beat. They are visible in the following cycle.
- Back-to-back frames: a sof beat on the cycle immediately after completion is accepted, so the link sustains 1 beat/clk with no bubble.
- y0..y3 hold their values between completed frames. Partial frames never disturb them.
- din and sof are ignored whenever din_valid=0.
- Wrap: cnt never exceeds 3. The cnt=3 beat always returns cnt to 0.

Test Plan:
- Reset: assert rst for 2 cycles, deasserting away from a clk edge -> all outputs 0; first sof beat afterwards is accepted normally.
- Frame {d3,d2,d1,d0}=1001 (W=1), beats 1(sof),0,0,1 on consecutive cycles -> after 4th edge y0=1, y1=0, y2=0, y3=1, frame_valid=1 for exactly 1 cycle; sel steps 1,2,3,0; busy high for 3 cycles.
- Frame 0110 immediately following, with 2 idle cycles (din_valid=0) between beats 2 and 3 -> y0=0, y1=1, y2=1, y3=0 only at the 4th beat; y holds 1001 during the gaps.
- Early sof: beats 1(sof),1, then 0(sof),1,1,0 -> frame_err pulses once at the third beat, y unchanged at that point; then y0=0, y1=1, y2=1, y3=0 with one frame_valid pulse.
- Beats with sof=0 while IDLE (din=1, 3 beats) -> no state change, sel=0, busy=0, no pulses.
- rst asserted asynchronously after 2 beats of a frame -> sel=0, busy=0, y=0 immediately; next full frame 1001 decodes correctly.
